// File: rtl/alu_pkg.sv
// Shared ALU definitions for the bitwise logic units: default width, word
// type and the zero/all-ones status flag pair.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef logic [ALU_WIDTH-1:0] alu_word_t;

  typedef struct packed {
    logic zero;
    logic ones;
  } alu_flags_t;

endpackage

// File: rtl/and_bitwise.sv
// Purely combinational AND of two W-bit slices; the core instantiates one
// of these per result bit.
module and_bitwise #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = a & b;

endmodule

// File: rtl/and_32bit_core.sv
// Registered bitwise-AND slice of the ALU: y = a & b one clock after an
// in_valid strobe, with zero/all-ones flags registered alongside y.
module and_32bit_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             zero,
  output logic             ones
);

  // Handshake: valid-only, no ready. A beat is taken on every rising edge
  // with in_valid=1; out_valid is in_valid delayed one cycle, and y/flags
  // keep their last value while out_valid=0.

  logic [WIDTH-1:0] and_w;
  logic [WIDTH-1:0] y_q;
  logic             valid_q;
  alu_flags_t       flags_d;
  alu_flags_t       flags_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    and_bitwise #(.W(1)) u_and (
      .a (a[i]),
      .b (b[i]),
      .y (and_w[i])
    );
  end

  // Flags are reduced from the value about to be registered, so they always
  // agree with y on the following cycle.
  always_comb begin
    flags_d      = '0;
    flags_d.zero = (and_w == '0);
    flags_d.ones = (and_w == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      y_q          <= '0;
      flags_q.zero <= 1'b1;
      flags_q.ones <= 1'b0;
    end else begin
      valid_q <= in_valid;
      // Operands are only sampled when valid; idle cycles hold y and flags.
      if (in_valid) begin
        y_q     <= and_w;
        flags_q <= flags_d;
      end
    end
  end

  assign y         = y_q;
  assign out_valid = valid_q;
  assign zero      = flags_q.zero;
  assign ones      = flags_q.ones;

endmodule

// File: tb/tb_and_32bit_core.sv
// Directed and random checks of and_32bit_core against hand-computed values
// and a small reference model.
module tb_and_32bit_core;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y;
  logic         out_valid;
  logic         zero;
  logic         ones;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_y;
  logic         m_valid;

  and_32bit_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .y         (y),
    .out_valid (out_valid),
    .zero      (zero),
    .ones      (ones)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; the model tracks what the outputs must show afterwards.
  task automatic cycle(input logic v, input logic [W-1:0] av,
                       input logic [W-1:0] bv);
    in_valid = v;
    a        = av;
    b        = bv;
    if (rst) begin
      m_y     = '0;
      m_valid = 1'b0;
    end else begin
      m_valid = v;
      if (v) m_y = av & bv;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".y"}, y, m_y);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, (m_y == '0)});
    check({tag, ".ones"}, {31'd0, ones}, {31'd0, (m_y == '1)});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    m_y = '0; m_valid = 1'b0;

    // Reset wins over a valid all-ones input
    cycle(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    cycle(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("rst.y", y, 32'h00000000);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.zero", {31'd0, zero}, 32'd1);
    check("rst.ones", {31'd0, ones}, 32'd0);
    rst = 1'b0;

    // Basic transaction, then idle holds y
    cycle(1'b1, 32'h00000005, 32'hFFFFFFFD);
    check("basic.y", y, 32'h00000005);
    check("basic.out_valid", {31'd0, out_valid}, 32'd1);
    check("basic.zero", {31'd0, zero}, 32'd0);
    check("basic.ones", {31'd0, ones}, 32'd0);
    cycle(1'b0, 32'h12345678, 32'hDEADBEEF);
    check("idle.out_valid", {31'd0, out_valid}, 32'd0);
    check("idle.y", y, 32'h00000005);

    // Flags
    cycle(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("ones.y", y, 32'hFFFFFFFF);
    check("ones.ones", {31'd0, ones}, 32'd1);
    check("ones.zero", {31'd0, zero}, 32'd0);
    cycle(1'b1, 32'hAAAAAAAA, 32'h55555555);
    check("zero.y", y, 32'h00000000);
    check("zero.zero", {31'd0, zero}, 32'd1);
    check("zero.ones", {31'd0, ones}, 32'd0);

    // Back-to-back
    exp_q.push_back(32'hF000F000);
    exp_q.push_back(32'h00005678);
    exp_q.push_back(32'h80000000);
    cycle(1'b1, 32'hF0F0F0F0, 32'hFF00FF00);
    check("b2b0.y", y, exp_q.pop_front());
    check("b2b0.out_valid", {31'd0, out_valid}, 32'd1);
    cycle(1'b1, 32'h12345678, 32'h0000FFFF);
    check("b2b1.y", y, exp_q.pop_front());
    check("b2b1.out_valid", {31'd0, out_valid}, 32'd1);
    cycle(1'b1, 32'h80000001, 32'h80000000);
    check("b2b2.y", y, exp_q.pop_front());
    check("b2b2.out_valid", {31'd0, out_valid}, 32'd1);
    cycle(1'b0, 32'h0, 32'h0);
    check("b2b_idle.out_valid", {31'd0, out_valid}, 32'd0);
    check("b2b_idle.y", y, 32'h80000000);

    // Reset mid-stream discards the concurrent transaction
    rst = 1'b1;
    cycle(1'b1, 32'hFFFFFFFF, 32'h0F0F0F0F);
    check("rst_mid.y", y, 32'h00000000);
    check("rst_mid.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid.zero", {31'd0, zero}, 32'd1);
    rst = 1'b0;
    cycle(1'b1, 32'hFFFFFFFF, 32'h0F0F0F0F);
    check("post_rst.y", y, 32'h0F0F0F0F);
    check("post_rst.out_valid", {31'd0, out_valid}, 32'd1);

    // Random traffic against the model, with occasional all-ones/zero corners
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 15) == 0) begin ra = '1; rb = '1; end
      if ($urandom_range(0, 15) == 0) rb = ~ra;
      cycle(logic'($urandom_range(0, 1)), ra, rb);
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
